// File: rtl/skid_pkg.sv
// rtl/skid_pkg.sv - shared FSM state encoding and pattern constants for skid_stream_src
package skid_pkg;

    localparam int GAP_W = 4;

    // Fibonacci taps: feedback = bit7 ^ bit5 ^ bit4 ^ bit3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/skid_pat_gen.sv
// rtl/skid_pat_gen.sv - next beat value; SKID_SRC_LFSR_EN selects LFSR, else incrementing
module skid_pat_gen
    import skid_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_cur,
    output logic [DW-1:0] o_next
);

`ifdef SKID_SRC_LFSR_EN
    generate
        if (DW != 8) begin : g_bad_dw
            $error("skid_pat_gen: LFSR pattern requires DW == 8");
        end
    endgenerate

    assign o_next = {i_cur[DW-2:0], ^(i_cur & DW'(LFSR_TAPS))};
`else
    assign o_next = i_cur + DW'(1);
`endif

endmodule

// File: rtl/skid_stream_src.sv
// rtl/skid_stream_src.sv - burst beat source feeding a skid buffer; SKID_SRC_LFSR_EN selects LFSR data
module skid_stream_src
    import skid_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [GAP_W-1:0] i_gap,
    input  logic [DW-1:0]    i_seed,
    output logic             o_val,
    output logic [DW-1:0]    o_bus,
    input  logic             i_rdy,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_beats
);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_val;
    logic [DW-1:0]    r_bus;
    logic             r_busy;
    logic             r_done;
    logic [LEN_W-1:0] r_beats;

    logic [DW-1:0]    w_next;
    logic [DW-1:0]    w_seed;
    logic [LEN_W-1:0] w_beats_inc;
    logic             w_last;

    skid_pat_gen #(.DW(DW)) u_pat_gen (
        .i_cur  (r_bus),
        .o_next (w_next)
    );

`ifdef SKID_SRC_LFSR_EN
    // an all-zero LFSR state would lock up
    assign w_seed = (i_seed == '0) ? DW'(1) : i_seed;
`else
    assign w_seed = i_seed;
`endif

    assign w_beats_inc = r_beats + LEN_W'(1);
    assign w_last      = (w_beats_inc == r_len);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_val     <= 1'b0;
            r_bus     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_beats   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_len   <= i_len;
                        r_gap   <= i_gap;
                        r_beats <= '0;
                        r_busy  <= 1'b1;
                        if (i_len != '0) begin
                            r_state <= ST_SEND;
                            r_val   <= 1'b1;
                            r_bus   <= w_seed;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    // o_val is always high here, so i_rdy alone marks a transfer
                    if (i_rdy) begin
                        r_beats <= w_beats_inc;
                        r_bus   <= w_next;
                        if (w_last) begin
                            r_val   <= 1'b0;
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (r_gap != '0) begin
                            r_val     <= 1'b0;
                            r_gap_cnt <= r_gap;
                            r_state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(1)) begin
                        r_val   <= 1'b1;
                        r_state <= ST_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_val   = r_val;
    assign o_bus   = r_bus;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_beats = r_beats;

endmodule

// File: tb/tb_skid_stream_src.sv
// tb/tb_skid_stream_src.sv - randomized self-checking bench for skid_stream_src (SKID_SRC_LFSR_EN aware)
module tb_skid_stream_src;

    localparam int DW    = 8;
    localparam int LEN_W = 8;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic [3:0]       i_gap;
    logic [DW-1:0]    i_seed;
    logic             i_rdy;
    logic             o_val;
    logic [DW-1:0]    o_bus;
    logic             o_busy;
    logic             o_done;
    logic [LEN_W-1:0] o_beats;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mon_xq[$];
    int         mon_xi[$];
    bit         mon_vq[$];
    int         mon_done_cnt;
    int         mon_done_idx;
    int         mon_last_x;
    int         mon_stab_err;
    logic [7:0] mon_beats_end;
    bit         mon_busy_end;

    skid_stream_src #(.DW(DW), .LEN_W(LEN_W)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_len   (i_len),
        .i_gap   (i_gap),
        .i_seed  (i_seed),
        .o_val   (o_val),
        .o_bus   (o_bus),
        .i_rdy   (i_rdy),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_beats (o_beats)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] model_first(input logic [7:0] seed);
`ifdef SKID_SRC_LFSR_EN
        return (seed == 8'h00) ? 8'h01 : seed;
`else
        return seed;
`endif
    endfunction

    function automatic logic [7:0] model_next(input logic [7:0] v);
`ifdef SKID_SRC_LFSR_EN
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
        return v + 8'd1;
`endif
    endfunction

    function automatic logic [7:0] model_val(input logic [7:0] seed, input int k);
        logic [7:0] v;
        v = model_first(seed);
        for (int j = 0; j < k; j++) v = model_next(v);
        return v;
    endfunction

    task automatic tick;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // mode 0: ready always; mode 1: random ready; mode 2: stall 5 cycles on stall_val
    task automatic do_burst(input int len, input int gap, input logic [7:0] seed,
                            input int mode, input logic [7:0] stall_val, input bit mid_start);
        bit         timeout;
        bit         prev_stall;
        logic [7:0] prev_bus;
        int         stall_left;
        logic       rdy;
        mon_xq.delete();
        mon_xi.delete();
        mon_vq.delete();
        mon_done_cnt = 0;
        mon_done_idx = -1;
        mon_last_x   = -1;
        mon_stab_err = 0;
        timeout      = 1'b1;
        prev_stall   = 1'b0;
        prev_bus     = 8'h00;
        stall_left   = 5;
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        i_gap   = 4'(gap);
        i_seed  = seed;
        i_rdy   = 1'b1;
        tick();
        i_start = 1'b0;
        i_len   = LEN_W'($urandom);
        i_gap   = 4'($urandom);
        i_seed  = 8'($urandom);
        for (int c = 0; c < 300; c++) begin
            if (prev_stall && !(o_val === 1'b1 && o_bus === prev_bus)) mon_stab_err++;
            mon_vq.push_back(o_val === 1'b1);
            if (o_done === 1'b1) begin
                mon_done_cnt++;
                if (mon_done_idx < 0) mon_done_idx = c;
            end
            if (mon_done_idx >= 0 && c > mon_done_idx) begin
                timeout = 1'b0;
                break;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (o_val === 1'b1 && o_bus === stall_val && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            i_rdy = rdy;
            if (mid_start && c == 2) begin
                i_start = 1'b1;
                i_len   = 8'd9;
                i_gap   = 4'd1;
                i_seed  = 8'h55;
            end else begin
                i_start = 1'b0;
            end
            if (o_val === 1'b1 && rdy) begin
                mon_xq.push_back(o_bus);
                mon_xi.push_back(c);
                mon_last_x = c;
            end
            prev_stall = (o_val === 1'b1) && !rdy;
            prev_bus   = o_bus;
            tick();
        end
        i_start       = 1'b0;
        i_rdy         = 1'b1;
        mon_beats_end = o_beats;
        mon_busy_end  = o_busy;
        n_tests++;
        if (timeout) begin
            n_fail++;
            $display("FAIL burst_timeout: len=%0d gap=%0d no o_done within cycle budget", len, gap);
        end
    endtask

    task automatic test_reset;
        bit bad;
        i_reset = 1'b1;
        #80;
        n_tests++;
        if ({o_val, o_bus, o_busy, o_done, o_beats} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got val=%b bus=%h busy=%b done=%b beats=%0d expected all 0",
                     o_val, o_bus, o_busy, o_done, o_beats);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        tick();
        i_start = 1'b1; i_len = 8'd6; i_gap = 4'd0; i_seed = 8'h20; i_rdy = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        n_tests++;
        if (o_beats !== 8'd2 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_beats: got beats=%0d busy=%b expected 2 1", o_beats, o_busy);
        end
        #2 i_reset = 1'b1;
        #1;
        n_tests++;
        if ({o_val, o_bus, o_busy, o_done, o_beats} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got val=%b bus=%h busy=%b done=%b beats=%0d expected all 0",
                     o_val, o_bus, o_busy, o_done, o_beats);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (o_done !== 1'b0 || o_val !== 1'b0 || o_busy !== 1'b0) bad = 1'b1;
            tick();
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_no_done: got activity after mid-burst reset expected none");
        end
        do_burst(2, 0, 8'h10, 0, 8'h00, 1'b0);
        n_tests++;
        if (mon_xq.size() != 2 || mon_xq[0] !== model_val(8'h10, 0) || mon_xq[1] !== model_val(8'h10, 1)
            || mon_beats_end !== 8'd2 || mon_done_idx != 2) begin
            n_fail++;
            $display("FAIL reset_fresh: got n=%0d beats=%0d done_idx=%0d expected 2 2 2",
                     mon_xq.size(), mon_beats_end, mon_done_idx);
        end
    endtask

    task automatic test_basic;
        do_burst(4, 0, 8'hB3, 0, 8'h00, 1'b0);
        n_tests++;
        if (mon_xq.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected 4", mon_xq.size());
        end
        for (int k = 0; k < 4 && k < mon_xq.size(); k++) begin
            n_tests++;
            if (mon_xq[k] !== model_val(8'hB3, k) || mon_xi[k] != k) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got %h@%0d expected %h@%0d",
                         k, mon_xq[k], mon_xi[k], model_val(8'hB3, k), k);
            end
        end
        n_tests++;
        if (mon_done_idx != 4 || mon_done_cnt != 1 || mon_beats_end !== 8'd4 || mon_busy_end !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got idx=%0d cnt=%0d beats=%0d busy=%b expected 4 1 4 0",
                     mon_done_idx, mon_done_cnt, mon_beats_end, mon_busy_end);
        end
    endtask

    task automatic test_stall;
        logic [7:0] sv;
        sv = model_val(8'hF9, 1);
        do_burst(3, 0, 8'hF9, 2, sv, 1'b0);
        n_tests++;
        if (mon_stab_err != 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d unstable cycles expected 0", mon_stab_err);
        end
        n_tests++;
        if (mon_xq.size() != 3 || mon_xq[0] !== model_val(8'hF9, 0) || mon_xq[1] !== sv
            || mon_xq[2] !== model_val(8'hF9, 2)) begin
            n_fail++;
            $display("FAIL stall_data: got n=%0d expected 3 beats from seed f9", mon_xq.size());
        end
        n_tests++;
        if (mon_last_x != 7 || mon_done_idx != 8) begin
            n_fail++;
            $display("FAIL stall_timing: got last=%0d done=%0d expected 7 8", mon_last_x, mon_done_idx);
        end
    endtask

    task automatic test_gap;
        bit exp_v[$];
        bit bad;
        logic [7:0] seed;
        seed = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            exp_v.push_back(1'b1);
            if (k < 2) for (int g = 0; g < 2; g++) exp_v.push_back(1'b0);
        end
        do_burst(3, 2, seed, 0, 8'h00, 1'b1);
        bad = (mon_vq.size() < exp_v.size());
        for (int i = 0; i < exp_v.size() && i < mon_vq.size(); i++)
            if (mon_vq[i] != exp_v[i]) bad = 1'b1;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL gap_pattern: got o_val trace mismatch expected 1001001");
        end
        n_tests++;
        if (mon_done_idx != exp_v.size() || mon_xq.size() != 3 || mon_beats_end !== 8'd3
            || mon_xq[2] !== model_val(seed, 2)) begin
            n_fail++;
            $display("FAIL gap_done: got idx=%0d n=%0d beats=%0d expected %0d 3 3",
                     mon_done_idx, mon_xq.size(), mon_beats_end, exp_v.size());
        end
    endtask

    task automatic test_zero_len;
        int ones;
        do_burst(0, 1, 8'h42, 1, 8'h00, 1'b0);
        ones = 0;
        foreach (mon_vq[i]) if (mon_vq[i]) ones++;
        n_tests++;
        if (ones != 0 || mon_xq.size() != 0) begin
            n_fail++;
            $display("FAIL zero_val: got %0d valid cycles expected 0", ones);
        end
        n_tests++;
        if (mon_done_cnt != 1 || mon_done_idx != 0 || mon_beats_end !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_done: got cnt=%0d idx=%0d beats=%0d expected 1 0 0",
                     mon_done_cnt, mon_done_idx, mon_beats_end);
        end
    endtask

    task automatic test_random;
        int len, gap, gap_err, data_err;
        logic [7:0] seed;
        for (int it = 0; it < 8; it++) begin
            len  = $urandom_range(1, 8);
            gap  = $urandom_range(0, 3);
            seed = (it == 0) ? 8'hFD : 8'($urandom);
            do_burst(len, gap, seed, 1, 8'h00, 1'b0);
            data_err = (mon_xq.size() != len) ? 1 : 0;
            for (int k = 0; k < mon_xq.size() && k < len; k++)
                if (mon_xq[k] !== model_val(seed, k)) data_err++;
            n_tests++;
            if (data_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_data: got %0d bad beats (n=%0d) expected 0 of %0d",
                         it, data_err, mon_xq.size(), len);
            end
            gap_err = 0;
            for (int k = 0; k + 1 < mon_xi.size(); k++) begin
                for (int g = 1; g <= gap; g++)
                    if (mon_xi[k] + g >= mon_vq.size() || mon_vq[mon_xi[k] + g]) gap_err++;
                if (mon_xi[k] + gap + 1 >= mon_vq.size() || !mon_vq[mon_xi[k] + gap + 1]) gap_err++;
            end
            n_tests++;
            if (gap_err != 0 || mon_stab_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_gap: got gap_err=%0d stab_err=%0d expected 0 0",
                         it, gap_err, mon_stab_err);
            end
            n_tests++;
            if (mon_done_idx != mon_last_x + 1 || mon_done_cnt != 1 || mon_beats_end !== 8'(len)) begin
                n_fail++;
                $display("FAIL rand%0d_done: got idx=%0d cnt=%0d beats=%0d expected %0d 1 %0d",
                         it, mon_done_idx, mon_done_cnt, mon_beats_end, mon_last_x + 1, len);
            end
        end
    endtask

`ifdef SKID_SRC_LFSR_EN
    task automatic test_lfsr;
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04; exp_seq[3] = 8'h08;
        for (int s = 0; s < 2; s++) begin
            do_burst(4, 0, (s == 0) ? 8'h01 : 8'h00, 0, 8'h00, 1'b0);
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (k >= mon_xq.size() || mon_xq[k] !== exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL lfsr_s%0d_beat%0d: got %h expected %h", s, k,
                             (k < mon_xq.size()) ? mon_xq[k] : 8'hxx, exp_seq[k]);
                end
            end
        end
    endtask
`endif

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_len   = '0;
        i_gap   = '0;
        i_seed  = '0;
        i_rdy   = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_gap();
        test_zero_len();
        test_random();
`ifdef SKID_SRC_LFSR_EN
        test_lfsr();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/skid_stream_src.md
SKID_STREAM_SRC -- requirements
Module: skid_stream_src

Interface
REQ-001 Parameter DW, default 8, beat data width in bits.
REQ-002 Parameter LEN_W, default 8, width of burst-length and beat counters.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  reset, asynchronous and active-high.
REQ-005 i_start  input  1  burst request, sampled on rising edge.
REQ-006 i_len  input  LEN_W  number of beats in the burst, latched at accepted start.
REQ-007 i_gap  input  4  idle cycles inserted after each transfer, latched at accepted start.
REQ-008 i_seed  input  DW  first beat value, latched at accepted start.
REQ-009 o_val  output  1  beat valid toward the downstream skid buffer (drives up_val).
REQ-010 o_bus  output  DW  beat data (drives up_bus).
REQ-011 i_rdy  input  1  downstream ready (from up_rdy).
REQ-012 o_busy  output  1  high whenever state is not IDLE.
REQ-013 o_done  output  1  one-cycle pulse when the burst completes.
REQ-014 o_beats  output  LEN_W  count of transfers in the current or last burst.

Function
REQ-015 A transfer shall occur on a rising edge where o_val and i_rdy are both high.
REQ-016 All outputs shall be registered; no combinational path from i_rdy to any output.
REQ-017 The FSM shall have exactly the states IDLE, SEND, GAP, and DONE.
REQ-018 In IDLE, i_start with i_len>0 shall: latch inputs; clear o_beats; enter SEND with o_val=1 and o_bus=i_seed on the following cycle.
REQ-019 In IDLE, i_start with i_len==0 shall enter DONE directly, with no o_val assertion.
REQ-020 i_start outside IDLE shall be ignored.
REQ-021 Once o_val is high, o_val and o_bus shall hold stable until a transfer occurs.
REQ-022 On each transfer, o_beats shall increment and o_bus shall advance to the next pattern value.
REQ-023 On a non-last transfer with gap 0, o_val shall stay high: one beat per cycle.
REQ-024 On a non-last transfer with gap G>0, o_val shall drop for exactly G cycles (GAP), then reassert.
REQ-025 On the last transfer (o_beats reaches latched length), o_val shall drop and the FSM shall enter DONE.
REQ-026 DONE shall last one cycle with o_done=1, then return to IDLE.
REQ-027 o_beats shall hold its final value in IDLE until the next accepted start.
REQ-028 The default pattern shall be incrementing, modulo 2^DW (8'hFF wraps to 8'h00).

Reset
REQ-029 Asserting i_reset at any time, including mid-burst, shall immediately force:
  - state=IDLE
  - o_val=0, o_bus=0, o_busy=0, o_done=0, o_beats=0
  - all latched registers to 0.
REQ-030 Reset mid-burst shall not produce o_done.

Configuration
REQ-031 With SKID_SRC_LFSR_EN defined, the next pattern value shall be an 8-bit Fibonacci LFSR step:
  - shift left;
  - feedback into bit0 = bit7^bit5^bit4^bit3;
  - seed 0 replaced by 8'h01;
  - DW other than 8 is an elaboration error.
REQ-032 Without SKID_SRC_LFSR_EN, the incrementing pattern of REQ-028 shall apply and no LFSR logic shall be present.

Structure
REQ-033 Package skid_pkg shall hold:
  - the FSM state typedef (IDLE, SEND, GAP, DONE);
  - LFSR tap mask constant 8'hB8;
  - gap width constant 4.
REQ-034 Pattern generation shall be a sub-module skid_pat_gen (current value in, next value out), selected by the macro.

Verification
REQ-035 Reset: hold i_reset high 80 ns -> all outputs 0; assert mid-burst after 2 beats -> outputs clear at once, no o_done, next start behaves fresh.
REQ-036 len=4, seed=8'hB3, gap=0, i_rdy=1 -> o_bus B3,B4,B5,B6 on 4 consecutive cycles; o_done one cycle later; o_beats=4.
REQ-037 len=3, seed=8'hF9, i_rdy low 5 cycles while beat FA is valid -> o_val and o_bus=FA stable throughout; 3 transfers total: F9,FA,FB.
REQ-038 len=3, gap=2, i_rdy=1 -> o_val pattern 1,0,0,1,0,0,1, then o_done; start asserted during the burst is ignored.
REQ-039 len=0 -> o_val never high; o_done pulses once; o_beats=0.
REQ-040 SKID_SRC_LFSR_EN, seed=8'h01, len=4 -> o_bus 01,02,04,08; seed 0 yields an identical sequence.
